// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving the select of the two-input mux stage.
// Latency: request sampled at edge n is granted after edge n; grants are held for at least HOLD cycles.
// Backpressure: level-sensitive req0/req1 must stay high until granted; a request dropped during the other hold window is lost.
//
// Ports:
//   clk            single clock, rising-edge
//   rst            synchronous active-high reset
//   req0, req1     level-sensitive requests from mux in0 / in1
//   sel            registered mux select (0 = in0, 1 = in1); holds its value while idle
//   gnt0, gnt1     one-hot-or-zero grants decoded from registered state
//   active         either grant asserted
module mux_sel_arbiter #(
  parameter int HOLD = 4,
  parameter int CW   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;
  logic          last_nxt;
  logic          sel_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;   // source 0 wins the first contended request
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;

    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? G0 : G1;
          cnt_nxt   = RELOAD;
        end else if (req0) begin
          state_nxt = G0;
          cnt_nxt   = RELOAD;
        end else if (req1) begin
          state_nxt = G1;
          cnt_nxt   = RELOAD;
        end
      end

      G0: begin
        // Inside the hold window every request change is ignored.
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else if (req1) begin
          state_nxt = G1;
          cnt_nxt   = RELOAD;
          last_nxt  = 1'b0;
        end else if (!req0) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end

      G1: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else if (req0) begin
          state_nxt = G0;
          cnt_nxt   = RELOAD;
          last_nxt  = 1'b1;
        end else if (!req1) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // sel is computed from the next state so it switches on the same edge as
  // the grants; in IDLE it keeps the last owner so the mux path stays put.
  always_comb begin
    sel_nxt = sel;
    if (state_nxt == G0) sel_nxt = 1'b0;
    else if (state_nxt == G1) sel_nxt = 1'b1;
  end

  assign gnt0   = (state == G0);
  assign gnt1   = (state == G1);
  assign active = gnt0 | gnt1;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  logic clk;
  logic rst;
  logic req0;
  logic req1;
  logic sel;
  logic gnt0;
  logic gnt1;
  logic active;

  int total;
  int bad;

  mux_sel_arbiter #(.HOLD(4), .CW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .sel    (sel),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_g0, input logic e_g1,
                         input logic e_sel);
    chk({tag, ".gnt0"},   gnt0,   e_g0);
    chk({tag, ".gnt1"},   gnt1,   e_g1);
    chk({tag, ".active"}, active, e_g0 | e_g1);
    chk({tag, ".sel"},    sel,    e_sel);
  endtask

  initial begin
    logic e0;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;

    // Reset held two cycles with both requests high.
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Continuous contention: blocks of 4, source 0 first.
    for (int k = 0; k < 20; k++) begin
      tick();
      e0 = ((k / 4) % 2) == 0;
      chk_all($sformatf("contend%0d", k), e0, ~e0, ~e0);
      chk($sformatf("mutex%0d", k), gnt0 & gnt1, 1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk_all("contend_release", 1'b0, 1'b0, 1'b0);

    // Single-cycle pulse on req0 still gets a full 4-cycle grant.
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk_all("pulse0", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_all($sformatf("pulse%0d", k), 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("pulse_idle", 1'b0, 1'b0, 1'b0);

    // Grant source 1, then release to IDLE: sel must stay 1.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk_all("g1_first", 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk_all("g1_last", 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all($sformatf("selhold%0d", k), 1'b0, 1'b0, 1'b1);
    end

    // Both request from IDLE with last=1: source 0 wins.
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    chk_all("prio_after_idle", 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk_all("prio_idle", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a G1 grant (cnt=2).
    req1 = 1'b1;
    tick();
    tick();
    chk_all("pre_rst_g1", 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("post_rst_g1", 1'b0, 1'b1, 1'b1);

    // Hold window expires with req1 still high and no rival: grant extends.
    tick();
    tick();
    tick();
    tick();
    chk_all("g1_extend", 1'b0, 1'b1, 1'b1);

    // Simultaneous release of 1 and request of 0 at cnt==0: direct handover.
    req1 = 1'b0;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk_all("handover", 1'b1, 1'b0, 1'b0);

    // A req1 pulse inside the G0 hold window is lost.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk_all("lost_a", 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("lost_b", 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("lost_idle", 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("lost_stay_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
